// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the byte-wide RAM port arbiter:
// FSM states, transfer-length codes and byte-lane utilities.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } arb_state_e;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Length code 3 is an alias for a full word.
  function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
    logic [2:0] n;
    case (len)
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF and MEM) handshakes plus the byte-wide RAM bus.
// master = pipeline/RAM side, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_done;
  logic [31:0]       if_data;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic              mem_stall;

  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;

  modport master (
    output if_req, if_addr, if_cancel,
    input  if_done, if_data, if_stall,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  mem_done, mem_rdata, mem_stall,
    output ram_din,
    input  ram_dout, ram_a, ram_wr
  );

  modport slave (
    input  if_req, if_addr, if_cancel,
    output if_done, if_data, if_stall,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output mem_done, mem_rdata, mem_stall,
    input  ram_din,
    output ram_dout, ram_a, ram_wr
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and load/store,
// serialising 1/2/4-byte little-endian transfers; MEM wins, nothing is pre-empted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  mem_port_arbiter_if.slave bus
);

  arb_state_e        state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [2:0]        nbytes_r;
  logic [31:0]       wdata_r;
  logic [2:0]        step_r;
  logic [31:0]       rd_buf_r;
  logic [ADDR_W-1:0] ram_a_r;
  logic [7:0]        ram_dout_r;
  logic              ram_wr_r;
  logic              if_done_r;
  logic              mem_done_r;
  logic [31:0]       if_data_r;
  logic [31:0]       mem_rdata_r;

  logic [1:0]        cap_idx_s;
  logic              issue_s;
  logic              last_cap_s;
  logic [31:0]       asm_s;

  // step_r counts edges since grant: byte step_r is issued, byte step_r-2 arrives on ram_din.
  assign cap_idx_s  = 2'(step_r - 3'd2);
  assign issue_s    = (step_r < nbytes_r);
  assign last_cap_s = (step_r == (nbytes_r + 3'd1));

  // Merge the byte currently on ram_din into the read assembly buffer.
  always_comb begin
    asm_s = rd_buf_r;
    case (cap_idx_s)
      2'd0:    asm_s[7:0]   = bus.ram_din;
      2'd1:    asm_s[15:8]  = bus.ram_din;
      2'd2:    asm_s[23:16] = bus.ram_din;
      default: asm_s[31:24] = bus.ram_din;
    endcase
  end

  // Arbitration FSM with byte issue/capture sequencing and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= '0;
      nbytes_r    <= 3'd0;
      wdata_r     <= 32'd0;
      step_r      <= 3'd0;
      rd_buf_r    <= 32'd0;
      ram_a_r     <= '0;
      ram_dout_r  <= 8'd0;
      ram_wr_r    <= 1'b0;
      if_done_r   <= 1'b0;
      mem_done_r  <= 1'b0;
      if_data_r   <= 32'd0;
      mem_rdata_r <= 32'd0;
    end else if (rdy) begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      ram_wr_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // A done pulse in flight forces a one-cycle bubble before the next grant.
          if (!if_done_r && !mem_done_r) begin
            if (bus.mem_req) begin
              addr_r   <= bus.mem_addr;
              nbytes_r <= len_to_nbytes(bus.mem_len);
              wdata_r  <= bus.mem_wdata;
              rd_buf_r <= 32'd0;
              ram_a_r  <= bus.mem_addr;
              step_r   <= 3'd1;
              if (bus.mem_we) begin
                state_r    <= ST_MEM_WR;
                ram_wr_r   <= 1'b1;
                ram_dout_r <= bus.mem_wdata[7:0];
              end else begin
                state_r <= ST_MEM_RD;
              end
            end else if (bus.if_req && !bus.if_cancel) begin
              state_r  <= ST_IF_RD;
              addr_r   <= bus.if_addr;
              nbytes_r <= 3'd4;
              rd_buf_r <= 32'd0;
              ram_a_r  <= bus.if_addr;
              step_r   <= 3'd1;
            end
          end
        end
        ST_IF_RD, ST_MEM_RD: begin
          if ((state_r == ST_IF_RD) && bus.if_cancel) begin
            state_r <= ST_IDLE;
          end else begin
            if (issue_s) begin
              ram_a_r <= addr_r + ADDR_W'(step_r);
            end
            if (step_r >= 3'd2) begin
              rd_buf_r <= asm_s;
            end
            if (last_cap_s) begin
              state_r <= ST_IDLE;
              if (state_r == ST_IF_RD) begin
                if_done_r <= 1'b1;
                if_data_r <= asm_s;
              end else begin
                mem_done_r  <= 1'b1;
                mem_rdata_r <= asm_s;
              end
            end
            step_r <= step_r + 3'd1;
          end
        end
        ST_MEM_WR: begin
          if (issue_s) begin
            ram_a_r    <= addr_r + ADDR_W'(step_r);
            ram_dout_r <= byte_sel(wdata_r, step_r[1:0]);
            ram_wr_r   <= 1'b1;
            step_r     <= step_r + 3'd1;
          end else begin
            mem_done_r <= 1'b1;
            state_r    <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_a     = ram_a_r;
  assign bus.ram_dout  = ram_dout_r;
  assign bus.ram_wr    = ram_wr_r & rdy;
  assign bus.if_done   = if_done_r;
  assign bus.if_data   = if_data_r;
  assign bus.mem_done  = mem_done_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.if_stall  = bus.if_req & ~if_done_r;
  assign bus.mem_stall = bus.mem_req & ~mem_done_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions plus
// hand-written sequences for priority, cancel, rdy pause and mid-transfer reset.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic rdy;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  typedef struct packed {
    logic        is_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic [7:0]  exp_cyc;
    logic [7:0]  exp_wr;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] ram_mem [128];
  int n_vec = 0;
  int n_err = 0;

  // Sparse address map onto a small array; all addresses used below are distinct.
  function automatic int ridx(input logic [31:0] a);
    return {25'd0, a[17], a[11:8], a[1:0]};
  endfunction

  // Synchronous RAM: data for the address latched at one edge appears after the next.
  always @(posedge clk) begin
    if (bus.ram_wr) ram_mem[ridx(bus.ram_a)] <= bus.ram_dout;
    bus.ram_din <= ram_mem[ridx(bus.ram_a)];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram_mem[ridx(a)] <= v;
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    int cyc;
    int wr_cnt;
    logic done;
    logic stall;
    logic [31:0] data;
    n = !v.is_mem ? 4 : (v.len == 2'd0 ? 1 : (v.len == 2'd1 ? 2 : 4));
    @(negedge clk);
    if (v.is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = v.we;
      bus.mem_len   = v.len;
      bus.mem_addr  = v.addr;
      bus.mem_wdata = v.wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    cyc = 0;
    wr_cnt = 0;
    done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ram_wr) wr_cnt++;
      if (cyc <= n) begin
        check("ram_a_seq", bus.ram_a, v.addr + 32'(cyc - 1));
        if (v.is_mem && v.we)
          check("ram_dout_seq", {24'd0, bus.ram_dout}, (v.wdata >> (8 * (cyc - 1))) & 32'hFF);
      end
      done = v.is_mem ? bus.mem_done : bus.if_done;
    end
    data  = v.is_mem ? bus.mem_rdata : bus.if_data;
    stall = v.is_mem ? bus.mem_stall : bus.if_stall;
    bus.if_req  = 1'b0;
    bus.mem_req = 1'b0;
    check("done_cycle", cyc, 32'(v.exp_cyc));
    check("ram_wr_count", wr_cnt, 32'(v.exp_wr));
    check("stall_in_done_cycle", {31'd0, stall}, 32'd0);
    if (!(v.is_mem && v.we)) check("read_data", data, v.exp_data);
  endtask

  initial begin
    int wr;
    int c_mem;
    int c_if;
    logic any_done;

    rst = 1'b0;
    rdy = 1'b1;
    bus.if_req = 1'b0;   bus.if_addr = 32'd0;  bus.if_cancel = 1'b0;
    bus.mem_req = 1'b0;  bus.mem_we = 1'b0;    bus.mem_len = 2'd0;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
    for (int i = 0; i < 128; i++) ram_mem[i] <= 8'h00;
    #1;
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h200, 8'h5A); poke(32'h201, 8'hFF);
    poke(32'hFFFF_FFFF, 8'hC3); poke(32'h0, 8'h7E); poke(32'h1, 8'h99);
    poke(32'h500, 8'h01); poke(32'h501, 8'h02); poke(32'h502, 8'h03); poke(32'h503, 8'h04);
    poke(32'h701, 8'h88);

    vecs[0] = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'h4433_2211, 8'd6, 8'd0};
    vecs[1] = '{1'b1, 1'b0, 2'd0, 32'h0000_0200, 32'h0,          32'h0000_005A, 8'd3, 8'd0};
    vecs[2] = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,          32'h0000_7EC3, 8'd4, 8'd0};
    vecs[3] = '{1'b1, 1'b1, 2'd2, 32'h0000_0300, 32'hDEAD_BEEF,  32'h0,         8'd5, 8'd4};
    vecs[4] = '{1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0,          32'hDEAD_BEEF, 8'd6, 8'd0};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 32'h0000_0400, 32'h1234_ABCD,  32'h0,         8'd3, 8'd2};
    vecs[6] = '{1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0,          32'h0000_ABCD, 8'd6, 8'd0};
    vecs[7] = '{1'b1, 1'b0, 2'd3, 32'h0000_0100, 32'h0,          32'h4433_2211, 8'd6, 8'd0};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 32'h0000_0700, 32'hFFFF_FF77,  32'h0,         8'd2, 8'd1};
    vecs[9] = '{1'b1, 1'b0, 2'd1, 32'h0000_0700, 32'h0,          32'h0000_8877, 8'd4, 8'd0};

    repeat (3) @(negedge clk);
    check("rst_ram_a",     bus.ram_a, 32'd0);
    check("rst_ram_wr",    {31'd0, bus.ram_wr}, 32'd0);
    check("rst_ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
    check("rst_if_done",   {31'd0, bus.if_done}, 32'd0);
    check("rst_mem_done",  {31'd0, bus.mem_done}, 32'd0);
    check("rst_if_data",   bus.if_data, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i]);

    // MEM store and IF fetch arrive together: store first, fetch after the bubble.
    @(negedge clk);
    bus.if_req = 1'b1;  bus.if_addr = 32'h100;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd0;
    bus.mem_addr = 32'h0002_0000; bus.mem_wdata = 32'h0000_00AB;
    wr = 0; c_mem = 0; c_if = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.ram_wr) wr++;
      if (c == 1) begin
        check("prio_ram_a",  bus.ram_a, 32'h0002_0000);
        check("prio_dout",   {24'd0, bus.ram_dout}, 32'hAB);
        check("prio_if_stall",  {31'd0, bus.if_stall}, 32'd1);
        check("prio_mem_stall", {31'd0, bus.mem_stall}, 32'd1);
      end
      if (c == 3) check("prio_bubble_ram_a", bus.ram_a, 32'h0002_0000);
      if (c == 4) check("prio_if_grant_a", bus.ram_a, 32'h100);
      if (bus.mem_done) begin
        if (c_mem == 0) c_mem = c;
        bus.mem_req = 1'b0;
      end
      if (bus.if_done) begin
        if (c_if == 0) begin
          c_if = c;
          check("prio_if_data", bus.if_data, 32'h4433_2211);
        end
        bus.if_req = 1'b0;
      end
    end
    check("prio_mem_done_cyc", c_mem, 32'd2);
    check("prio_if_done_cyc",  c_if,  32'd9);
    check("prio_wr_count",     wr,    32'd1);
    check("prio_ram_content",  {24'd0, ram_mem[ridx(32'h0002_0000)]}, 32'hAB);

    // Fetch cancelled in cycle 3; cancel held in IDLE must block a new grant.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    any_done = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus.if_done) any_done = 1'b1;
      if (c == 3) begin
        check("cancel_ram_a", bus.ram_a, 32'h502);
        bus.if_cancel = 1'b1;
      end
      if (c == 5) begin
        check("cancel_blocks_grant", bus.ram_a, 32'h502);
        check("cancel_if_stall", {31'd0, bus.if_stall}, 32'd1);
        bus.if_req = 1'b0;
        bus.if_cancel = 1'b0;
      end
      if (c == 6) check("cancel_if_stall_low", {31'd0, bus.if_stall}, 32'd0);
    end
    check("cancel_no_done", {31'd0, any_done}, 32'd0);
    check("cancel_if_data", bus.if_data, 32'h4433_2211);

    // Word store with rdy low across three edges mid-transfer.
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_len = 2'd2;
    bus.mem_addr = 32'h600; bus.mem_wdata = 32'hA1B2_C3D4;
    wr = 0; c_mem = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.ram_wr) wr++;
      if (c >= 3 && c <= 5) check("pause_ram_wr", {31'd0, bus.ram_wr}, 32'd0);
      if (c == 4) check("pause_ram_a", bus.ram_a, 32'h601);
      if (bus.mem_done && c_mem == 0) begin
        c_mem = c;
        bus.mem_req = 1'b0;
      end
      if (c == 2) rdy = 1'b0;
      if (c == 5) rdy = 1'b1;
    end
    check("pause_done_cyc", c_mem, 32'd8);
    check("pause_wr_count", wr, 32'd4);
    do_txn('{1'b1, 1'b0, 2'd2, 32'h600, 32'h0, 32'hA1B2_C3D4, 8'd6, 8'd0});

    // Asynchronous reset in the middle of a word load.
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_len = 2'd2; bus.mem_addr = 32'h100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_ram_a",     bus.ram_a, 32'd0);
    check("arst_ram_dout",  {24'd0, bus.ram_dout}, 32'd0);
    check("arst_if_data",   bus.if_data, 32'd0);
    check("arst_mem_rdata", bus.mem_rdata, 32'd0);
    bus.mem_req = 1'b0;
    repeat (2) @(negedge clk);
    check("arst_no_mem_done", {31'd0, bus.mem_done}, 32'd0);
    rst = 1'b1;
    do_txn(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
